pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage LEGv8 CPU.
- Watches the ID, EX and MEM stages and drives the PC and pipeline-register enables, bubbles and flushes.
- Resolves three hazard classes:
  - load-use data hazards
  - flag-use hazards (B.cond after a flag-setting instruction)
  - taken-branch redirects
- Freezes the whole pipe while data memory has not acknowledged a request.

Parameters:
LU_STALL, 1, bubble cycles inserted for a load-use hazard (1..7)
FLAG_STALL, 1, bubble cycles inserted for a flag-use hazard (1..7)
CNT_W, 32, width of the stall-cycle performance counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
id_valid  input  1  ID stage holds a real instruction
id_Rn  input  5  ID first source register
id_Rm  input  5  ID second source register (Rd for STUR/CBZ after Reg2Loc)
id_useRn  input  1  ID instruction reads id_Rn
id_useRm  input  1  ID instruction reads id_Rm
id_readsFlags  input  1  ID instruction is B.cond
ex_memRead  input  1  EX instruction is LDUR
ex_RegWrite  input  1  EX instruction writes a register
ex_Rd  input  5  EX destination register
ex_set_flags  input  1  EX instruction sets flags
br_taken  input  1  EX resolved a taken branch (B, BL, BR, CBZ, B.cond)
dmem_req  input  1  MEM stage has an outstanding load/store
dmem_ack  input  1  data memory completes the request this cycle
pc_en  output  1  PC register load enable
ifid_en  output  1  IF/ID register enable
idex_en  output  1  ID/EX register enable
exmem_en  output  1  EX/MEM and MEM/WB register enable
idex_bubble  output  1  load NOP control word into ID/EX
ifid_flush  output  1  clear IF/ID to NOP
idex_flush  output  1  clear ID/EX to NOP
state  output  2  0=RUN, 1=STALL, 2=MEMWAIT
stall_cycles  output  CNT_W  saturating count of cycles with pc_en=0 since reset

Behaviour:
- Register state: state, cnt[2:0], stall_cycles. Control outputs are combinational from the registered state plus the current inputs.
- Reset (rst=1 at a clk edge):
  - Next state: state=RUN, cnt=0, stall_cycles=0.
  - While rst=1: pc_en=ifid_en=idex_en=exmem_en=0, ifid_flush=idex_flush=1, idex_bubble=0.
  - Reset mid-stall or mid-MEMWAIT aborts immediately.
- Default (RUN, no event): all enables=1, all flush/bubble=0.
- Priority 1, MEMWAIT condition (dmem_req & !dmem_ack):
  - Outputs: pc_en=ifid_en=idex_en=exmem_en=0; flush=0 and bubble=0.
  - Next state=MEMWAIT; cnt holds; stall_cycles++.
  - br_taken is ignored while frozen, because EX is held and re-presents it.
- MEMWAIT with dmem_ack=1 (or dmem_req=0): leave the freeze and evaluate priorities 2-4 in the same cycle. Next state=STALL if cnt>0, else RUN.
- Priority 2, br_taken:
  - Outputs: ifid_flush=1, idex_flush=1, all enables=1.
  - Cancels any STALL: next state=RUN, cnt=0.
- Priority 3, state STALL:
  - Outputs: pc_en=0, ifid_en=0, idex_en=1, idex_bubble=1; stall_cycles++.
  - cnt decrements; if cnt==1 this cycle, next state=RUN.
- Priority 4, hazard detect (in RUN only). Register 31 (XZR) never matches.
  - lu_haz = id_valid & ex_memRead & ex_RegWrite & ex_Rd!=31 & ((id_useRn & id_Rn==ex_Rd) | (id_useRm & id_Rm==ex_Rd)).
  - fl_haz = id_valid & id_readsFlags & ex_set_flags.
  - On a hazard, the current cycle is bubble 1: pc_en=0, ifid_en=0, idex_bubble=1; stall_cycles++.
  - N = LU_STALL if lu_haz, else FLAG_STALL. If both hazards, N = max(LU_STALL, FLAG_STALL).
  - If N>1: next state=STALL, cnt=N-1. Else remain RUN.
- idex_bubble and idex_flush are never both 1 except under reset.
- stall_cycles saturates at 2^CNT_W-1 and does not wrap.
- Latency: hazard response is zero-cycle (combinational on the same cycle the hazard is visible). State updates on the next edge.

Test Plan:
- Reset: rst=1 for 2 cycles, dmem_req=1 -> enables=0, flushes=1, state=0, stall_cycles=0. Release -> all enables=1 next cycle.
- Load-use, LU_STALL=1: ex_memRead=1, ex_RegWrite=1, ex_Rd=5; id_useRn=1, id_Rn=5 -> exactly one cycle pc_en=0, idex_bubble=1, then RUN. Repeat with ex_Rd=31 -> no stall.
- Flag-use, FLAG_STALL=3: ex_set_flags=1, id_readsFlags=1 -> 3 consecutive bubble cycles, state 0->1->1->0, stall_cycles=3.
- Branch cancels stall, FLAG_STALL=3: br_taken=1 on the 2nd stall cycle -> ifid_flush=idex_flush=1, pc_en=1, next state=RUN, stall_cycles=2.
- Memory wait: dmem_req=1, dmem_ack=0 for 4 cycles, then ack -> 4 frozen cycles (all enables=0, state=2), stall_cycles=4, enables=1 on the ack cycle.
- MEMWAIT during load-use: lu_haz and dmem_req & !dmem_ack together -> freeze wins. On the ack cycle the bubble is inserted. Total pc_en=0 cycles = wait cycles + 1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_if
//  Description : Stage-status inputs and pipeline-control outputs between the
//                LEGv8 datapath and its hazard sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    // ID stage
    logic             id_valid;
    logic [4:0]       id_Rn;
    logic [4:0]       id_Rm;
    logic             id_useRn;
    logic             id_useRm;
    logic             id_readsFlags;
    // EX stage
    logic             ex_memRead;
    logic             ex_RegWrite;
    logic [4:0]       ex_Rd;
    logic             ex_set_flags;
    logic             br_taken;
    // MEM stage
    logic             dmem_req;
    logic             dmem_ack;
    // Pipeline control
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             idex_bubble;
    logic             ifid_flush;
    logic             idex_flush;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cycles;

    // Datapath side: reports stage status, receives control
    modport master (
        output id_valid, id_Rn, id_Rm, id_useRn, id_useRm, id_readsFlags,
        output ex_memRead, ex_RegWrite, ex_Rd, ex_set_flags, br_taken,
        output dmem_req, dmem_ack,
        input  pc_en, ifid_en, idex_en, exmem_en,
        input  idex_bubble, ifid_flush, idex_flush, state, stall_cycles
    );

    // Sequencer side
    modport slave (
        input  id_valid, id_Rn, id_Rm, id_useRn, id_useRm, id_readsFlags,
        input  ex_memRead, ex_RegWrite, ex_Rd, ex_set_flags, br_taken,
        input  dmem_req, dmem_ack,
        output pc_en, ifid_en, idex_en, exmem_en,
        output idex_bubble, ifid_flush, idex_flush, state, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Pipeline sequencer for the 5-stage LEGv8 CPU. Freezes the
//                pipe on outstanding data-memory requests, flushes on taken
//                branches and inserts bubbles for load-use and flag-use
//                hazards. Also counts cycles in which the PC was held.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int LU_STALL   = 1,
    parameter int FLAG_STALL = 1,
    parameter int CNT_W      = 32
) (
    input  wire logic           clk,
    input  wire logic           rst,
    pipe_hazard_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STALL   = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_t;

    localparam logic [2:0] c_LU_N    = 3'(LU_STALL);
    localparam logic [2:0] c_FLAG_N  = 3'(FLAG_STALL);
    localparam logic [2:0] c_MAX_N   = (c_LU_N > c_FLAG_N) ? c_LU_N : c_FLAG_N;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    logic [2:0]       r_cnt;
    logic [CNT_W-1:0] r_stallCycles;

    state_t           w_nextState;
    state_t           w_effState;
    logic [2:0]       w_nextCnt;
    logic [2:0]       w_hazN;
    logic             w_freeze;
    logic             w_luHaz;
    logic             w_flHaz;
    logic             w_pcEn;
    logic             w_ifidEn;
    logic             w_idexEn;
    logic             w_exmemEn;
    logic             w_bubble;
    logic             w_ifidFlush;
    logic             w_idexFlush;

    // Hazard detection; XZR (register 31) never produces a dependency
    always_comb begin
        w_freeze = bus.dmem_req & ~bus.dmem_ack;
        w_luHaz  = bus.id_valid & bus.ex_memRead & bus.ex_RegWrite &
                   (bus.ex_Rd != 5'd31) &
                   ((bus.id_useRn & (bus.id_Rn == bus.ex_Rd)) |
                    (bus.id_useRm & (bus.id_Rm == bus.ex_Rd)));
        w_flHaz  = bus.id_valid & bus.id_readsFlags & bus.ex_set_flags;
        if (w_luHaz && w_flHaz) begin
            w_hazN = c_MAX_N;
        end else if (w_luHaz) begin
            w_hazN = c_LU_N;
        end else begin
            w_hazN = c_FLAG_N;
        end
        // Leaving MEMWAIT resumes whatever was frozen: a pending stall if
        // bubbles remain, otherwise normal running
        if (r_state == ST_MEMWAIT) begin
            w_effState = (r_cnt != 3'd0) ? ST_STALL : ST_RUN;
        end else begin
            w_effState = r_state;
        end
    end

    // Next-state and control outputs, highest priority first
    always_comb begin
        w_pcEn      = 1'b1;
        w_ifidEn    = 1'b1;
        w_idexEn    = 1'b1;
        w_exmemEn   = 1'b1;
        w_bubble    = 1'b0;
        w_ifidFlush = 1'b0;
        w_idexFlush = 1'b0;
        w_nextState = ST_RUN;
        w_nextCnt   = 3'd0;
        if (rst) begin
            w_pcEn      = 1'b0;
            w_ifidEn    = 1'b0;
            w_idexEn    = 1'b0;
            w_exmemEn   = 1'b0;
            w_ifidFlush = 1'b1;
            w_idexFlush = 1'b1;
        end else if (w_freeze) begin
            // EX is held, so a taken branch is re-presented after the freeze
            w_pcEn      = 1'b0;
            w_ifidEn    = 1'b0;
            w_idexEn    = 1'b0;
            w_exmemEn   = 1'b0;
            w_nextState = ST_MEMWAIT;
            w_nextCnt   = r_cnt;
        end else if (bus.br_taken) begin
            // Redirect squashes the younger instructions, including the
            // stalled consumer, so any pending bubbles are dropped
            w_ifidFlush = 1'b1;
            w_idexFlush = 1'b1;
        end else if (w_effState == ST_STALL) begin
            w_pcEn      = 1'b0;
            w_ifidEn    = 1'b0;
            w_bubble    = 1'b1;
            w_nextCnt   = r_cnt - 3'd1;
            w_nextState = (r_cnt == 3'd1) ? ST_RUN : ST_STALL;
        end else if (w_luHaz || w_flHaz) begin
            // This cycle is the first bubble; the rest come from STALL
            w_pcEn   = 1'b0;
            w_ifidEn = 1'b0;
            w_bubble = 1'b1;
            if (w_hazN > 3'd1) begin
                w_nextState = ST_STALL;
                w_nextCnt   = w_hazN - 3'd1;
            end
        end
    end

    // State, remaining-bubble count and saturating stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_cnt         <= 3'd0;
            r_stallCycles <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            if (!w_pcEn && (r_stallCycles != c_CNT_MAX)) begin
                r_stallCycles <= r_stallCycles + c_CNT_ONE;
            end
        end
    end

    // Drive the interface outputs
    always_comb begin
        bus.pc_en        = w_pcEn;
        bus.ifid_en      = w_ifidEn;
        bus.idex_en      = w_idexEn;
        bus.exmem_en     = w_exmemEn;
        bus.idex_bubble  = w_bubble;
        bus.ifid_flush   = w_ifidFlush;
        bus.idex_flush   = w_idexFlush;
        bus.state        = r_state;
        bus.stall_cycles = r_stallCycles;
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Vector-table bench for pipe_hazard_ctrl with LU_STALL=1,
//                FLAG_STALL=3 and a 4-bit stall counter so saturation is
//                reachable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int K_RUN = 0;
    localparam int K_BUB = 1;
    localparam int K_FRZ = 2;
    localparam int K_BR  = 3;
    localparam int K_RST = 4;

    typedef struct {
        logic       rst;
        logic       idv;
        logic [4:0] rn;
        logic [4:0] rm;
        logic       urn;
        logic       urm;
        logic       rf;
        logic       mr;
        logic       rw;
        logic [4:0] rd;
        logic       sf;
        logic       br;
        logic       req;
        logic       ack;
        logic [3:0] en;   // {pc, ifid, idex, exmem}
        logic       bub;
        logic [1:0] fl;   // {ifid, idex}
        logic [1:0] st;
        logic [3:0] sc;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   nChecks = 0;
    int   nFail   = 0;
    vec_t tbl[$];
    vec_t sb[$];

    pipe_hazard_ctrl_if #(.CNT_W(4)) bus ();

    pipe_hazard_ctrl #(
        .LU_STALL   (1),
        .FLAG_STALL (3),
        .CNT_W      (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, idv, input logic [4:0] rn, rm,
                                input logic urn, urm, rf, mr, rw,
                                input logic [4:0] rd,
                                input logic sf, br, req, ack,
                                input int kind, input logic [1:0] st,
                                input logic [3:0] sc);
        vec_t v;
        v.rst = r;  v.idv = idv; v.rn = rn; v.rm = rm; v.urn = urn; v.urm = urm;
        v.rf = rf;  v.mr = mr;   v.rw = rw; v.rd = rd; v.sf = sf;   v.br = br;
        v.req = req; v.ack = ack; v.st = st; v.sc = sc;
        case (kind)
            K_BUB:   begin v.en = 4'b0011; v.bub = 1'b1; v.fl = 2'b00; end
            K_FRZ:   begin v.en = 4'b0000; v.bub = 1'b0; v.fl = 2'b00; end
            K_BR:    begin v.en = 4'b1111; v.bub = 1'b0; v.fl = 2'b11; end
            K_RST:   begin v.en = 4'b0000; v.bub = 1'b0; v.fl = 2'b11; end
            default: begin v.en = 4'b1111; v.bub = 1'b0; v.fl = 2'b00; end
        endcase
        return v;
    endfunction

    task automatic idle(input int k, input logic [1:0] st, input logic [3:0] sc);
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,k,st,sc));
    endtask

    // Memory handshake and branch only, no ID/EX hazard
    task automatic mem(input logic br, req, ack, input int k,
                       input logic [1:0] st, input logic [3:0] sc);
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,br,req,ack,k,st,sc));
    endtask

    // Load-use on X5 through Rn
    task automatic luh(input logic req, ack, input int k,
                       input logic [1:0] st, input logic [3:0] sc);
        tbl.push_back(mk(0,1,5,0,1,0,0,1,1,5,0,0,req,ack,k,st,sc));
    endtask

    // B.cond behind a flag-setting instruction
    task automatic flg(input int k, input logic [1:0] st, input logic [3:0] sc);
        tbl.push_back(mk(0,1,0,0,0,0,1,0,0,0,1,0,0,0,k,st,sc));
    endtask

    task automatic chk(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        rst               = v.rst;
        bus.id_valid      = v.idv;
        bus.id_Rn         = v.rn;
        bus.id_Rm         = v.rm;
        bus.id_useRn      = v.urn;
        bus.id_useRm      = v.urm;
        bus.id_readsFlags = v.rf;
        bus.ex_memRead    = v.mr;
        bus.ex_RegWrite   = v.rw;
        bus.ex_Rd         = v.rd;
        bus.ex_set_flags  = v.sf;
        bus.br_taken      = v.br;
        bus.dmem_req      = v.req;
        bus.dmem_ack      = v.ack;
    endtask

    task automatic compare(input vec_t e, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        chk({tag, " enables"}, int'({bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en}), int'(e.en));
        chk({tag, " bubble"}, int'(bus.idex_bubble), int'(e.bub));
        chk({tag, " flush"}, int'({bus.ifid_flush, bus.idex_flush}), int'(e.fl));
        chk({tag, " state"}, int'(bus.state), int'(e.st));
        chk({tag, " stall_cycles"}, int'(bus.stall_cycles), int'(e.sc));
        if (!e.rst) begin
            chk({tag, " bubble_vs_flush"},
                int'(bus.idex_bubble & (bus.ifid_flush | bus.idex_flush)), 0);
        end
    endtask

    initial begin
        // Reset held two cycles with a pending memory request
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0,1,0,K_RST,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0,1,0,K_RST,0,0));
        idle(K_RUN, 0, 0);
        // Load-use, one bubble; XZR, unused Rm, no RegWrite, invalid ID
        luh(0, 0, K_BUB, 0, 0);
        idle(K_RUN, 0, 1);
        tbl.push_back(mk(0,1,31,0,1,0,0,1,1,31,0,0,0,0,K_RUN,0,1));
        tbl.push_back(mk(0,1,7,7,0,1,0,1,1,7,0,0,0,0,K_BUB,0,1));
        tbl.push_back(mk(0,1,7,7,0,0,0,1,1,7,0,0,0,0,K_RUN,0,2));
        tbl.push_back(mk(0,1,5,0,1,0,0,1,0,5,0,0,0,0,K_RUN,0,2));
        tbl.push_back(mk(0,0,5,0,1,0,0,1,1,5,0,0,0,0,K_RUN,0,2));
        // Flag-use, three bubbles
        flg(K_BUB, 0, 2);
        flg(K_BUB, 1, 3);
        idle(K_BUB, 1, 4);
        idle(K_RUN, 0, 5);
        // Taken branch on the second STALL cycle cancels the rest
        flg(K_BUB, 0, 5);
        idle(K_BUB, 1, 6);
        mem(1, 0, 0, K_BR, 1, 7);
        idle(K_RUN, 0, 7);
        // Both hazards at once: the longer stall wins
        tbl.push_back(mk(0,1,3,0,1,0,1,1,1,3,1,0,0,0,K_BUB,0,7));
        idle(K_BUB, 1, 8);
        idle(K_BUB, 1, 9);
        idle(K_RUN, 0, 10);
        // Four-cycle memory wait, released on ack
        for (int i = 0; i < 4; i++) mem(0, 1, 0, K_FRZ, (i == 0) ? 2'd0 : 2'd2, 4'(10 + i));
        mem(0, 1, 1, K_RUN, 2, 14);
        idle(K_RUN, 0, 14);
        // Freeze beats load-use; bubble lands on the ack cycle; counter saturates
        luh(1, 0, K_FRZ, 0, 14);
        luh(1, 0, K_FRZ, 2, 15);
        luh(1, 0, K_FRZ, 2, 15);
        luh(1, 1, K_BUB, 2, 15);
        idle(K_RUN, 0, 15);
        // Freeze in the middle of a flag stall resumes the remaining bubbles
        flg(K_BUB, 0, 15);
        mem(0, 1, 0, K_FRZ, 1, 15);
        idle(K_BUB, 2, 15);
        idle(K_BUB, 1, 15);
        idle(K_RUN, 0, 15);
        // Branch ignored while frozen, taken on the ack cycle
        mem(1, 1, 0, K_FRZ, 0, 15);
        mem(1, 1, 1, K_BR, 2, 15);
        idle(K_RUN, 0, 15);
        // Reset mid-stall aborts it and clears the counter
        flg(K_BUB, 0, 15);
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0,K_RST,1,15));
        idle(K_RUN, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            sb.push_back(tbl[i]);
            @(negedge clk);
            compare(sb.pop_front(), i);
            @(posedge clk);
            #1;
        end

        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire
